// File: rtl/auth_engine.sv
// auth_engine: PIN authentication engine with per-account attempt counters and lock flags.
// Defining AUTH_PIN_CHANGE_EN adds an in-band PIN change carried on a successful request.
module auth_engine #(
   parameter int NUM_ACCOUNTS = 10,
   parameter int ACC_W        = 4,
   parameter int PIN_W        = 14,
   parameter int MAX_TRIES    = 3,
   parameter int CNT_W        = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ACC_W-1:0]        req_acc_i,
   input  logic [PIN_W-1:0]        req_pin_i,
`ifdef AUTH_PIN_CHANGE_EN
   input  logic                    req_chg_i,
   input  logic [PIN_W-1:0]        req_new_pin_i,
`endif
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [2:0]              resp_code_o,
   output logic [CNT_W-1:0]        resp_tries_left_o,
   input  logic                    unlock_valid_i,
   input  logic [ACC_W-1:0]        unlock_acc_i,
   output logic [NUM_ACCOUNTS-1:0] locked_vec_o
);

   localparam int ACC_N       = 1 << ACC_W;
   localparam int DEF_ENTRIES = 10;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [2:0] CODE_OK      = 3'd0;
   localparam logic [2:0] CODE_BAD_PIN = 3'd1;
   localparam logic [2:0] CODE_LOCKED  = 3'd2;
   localparam logic [2:0] CODE_INVALID = 3'd3;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

   function automatic logic [PIN_W-1:0] defaultPin(input int idx);
      logic [PIN_W-1:0] pin;
      case (idx)
         0:       pin = PIN_W'(1234);
         1:       pin = PIN_W'(2345);
         2:       pin = PIN_W'(3456);
         3:       pin = PIN_W'(4567);
         4:       pin = PIN_W'(5678);
         5:       pin = PIN_W'(6789);
         6:       pin = PIN_W'(7890);
         7:       pin = PIN_W'(8901);
         8:       pin = PIN_W'(9012);
         9:       pin = PIN_W'(7123);
         default: pin = '0;
      endcase
      return pin;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] reqAcc_q, reqAcc_d;
   logic [PIN_W-1:0] reqPin_q, reqPin_d;
   logic [2:0]       respCode_q, respCode_d;
   logic [CNT_W-1:0] triesLeft_q, triesLeft_d;
   logic [ACC_N-1:0] lock_q, lock_d;
   logic [CNT_W-1:0] tryCnt_q [ACC_N];
   logic [CNT_W-1:0] tryCnt_d [ACC_N];
   logic [PIN_W-1:0] pinTable_q [ACC_N];
   logic [PIN_W-1:0] pinTable_d [ACC_N];

   logic             accOk;
   logic             unlockOk;
   logic             isLocked;
   logic             pinMatch;
   logic [CNT_W-1:0] curCnt;
   logic [CNT_W-1:0] bumpCnt;
   logic             badNewPin;
   logic             wrPin;
   logic [PIN_W-1:0] newPinVal;

`ifdef AUTH_PIN_CHANGE_EN
   logic             chg_q, chg_d;
   logic [PIN_W-1:0] newPin_q, newPin_d;

   assign badNewPin = chg_q && (newPin_q > PIN_W'(9999));
   assign wrPin     = chg_q;
   assign newPinVal = newPin_q;
`else
   assign badNewPin = 1'b0;
   assign wrPin     = 1'b0;
   assign newPinVal = reqPin_q;
`endif

   // Only the first DEF_ENTRIES indices are provisioned; the rest reject like out-of-range accounts.
   assign accOk    = (int'(reqAcc_q) < NUM_ACCOUNTS) && (int'(reqAcc_q) < DEF_ENTRIES);
   assign unlockOk = int'(unlock_acc_i) < NUM_ACCOUNTS;
   assign isLocked = lock_q[reqAcc_q];
   assign pinMatch = pinTable_q[reqAcc_q] == reqPin_q;
   assign curCnt   = tryCnt_q[reqAcc_q];
   assign bumpCnt  = curCnt + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      reqAcc_d    = reqAcc_q;
      reqPin_d    = reqPin_q;
      respCode_d  = respCode_q;
      triesLeft_d = triesLeft_q;
      lock_d      = lock_q;
      tryCnt_d    = tryCnt_q;
      pinTable_d  = pinTable_q;
`ifdef AUTH_PIN_CHANGE_EN
      chg_d       = chg_q;
      newPin_d    = newPin_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               reqAcc_d = req_acc_i;
               reqPin_d = req_pin_i;
`ifdef AUTH_PIN_CHANGE_EN
               chg_d    = req_chg_i;
               newPin_d = req_new_pin_i;
`endif
               state_d  = CHECK;
            end
         end
         CHECK: begin
            state_d = RESP;
            if (!accOk) begin
               respCode_d  = CODE_INVALID;
               triesLeft_d = '0;
            end else if (isLocked) begin
               respCode_d  = CODE_LOCKED;
               triesLeft_d = '0;
            end else if (pinMatch && !badNewPin) begin
               respCode_d         = CODE_OK;
               triesLeft_d        = MAX_CNT;
               tryCnt_d[reqAcc_q] = '0;
               if (wrPin) begin
                  pinTable_d[reqAcc_q] = newPinVal;
               end
            end else if (pinMatch) begin
               respCode_d  = CODE_BAD_PIN;
               triesLeft_d = MAX_CNT - curCnt;
            end else if (bumpCnt == MAX_CNT) begin
               respCode_d         = CODE_LOCKED;
               triesLeft_d        = '0;
               tryCnt_d[reqAcc_q] = '0;
               lock_d[reqAcc_q]   = 1'b1;
            end else begin
               respCode_d         = CODE_BAD_PIN;
               triesLeft_d        = MAX_CNT - bumpCnt;
               tryCnt_d[reqAcc_q] = bumpCnt;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Applied last so an unlock overrides a lock set by a same-cycle check on that account.
      if (unlock_valid_i && unlockOk) begin
         lock_d[unlock_acc_i]   = 1'b0;
         tryCnt_d[unlock_acc_i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         reqAcc_q    <= '0;
         reqPin_q    <= '0;
         respCode_q  <= '0;
         triesLeft_q <= '0;
         lock_q      <= '0;
         for (int i = 0; i < ACC_N; i++) begin
            tryCnt_q[i]   <= '0;
            pinTable_q[i] <= defaultPin(i);
         end
`ifdef AUTH_PIN_CHANGE_EN
         chg_q       <= 1'b0;
         newPin_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         reqAcc_q    <= reqAcc_d;
         reqPin_q    <= reqPin_d;
         respCode_q  <= respCode_d;
         triesLeft_q <= triesLeft_d;
         lock_q      <= lock_d;
         tryCnt_q    <= tryCnt_d;
         pinTable_q  <= pinTable_d;
`ifdef AUTH_PIN_CHANGE_EN
         chg_q       <= chg_d;
         newPin_q    <= newPin_d;
`endif
      end
   end

   assign req_ready_o       = state_q == IDLE;
   assign resp_valid_o      = state_q == RESP;
   assign resp_code_o       = respCode_q;
   assign resp_tries_left_o = triesLeft_q;
   assign locked_vec_o      = lock_q[NUM_ACCOUNTS-1:0];

endmodule

// File: tb/tb_auth_engine.sv
// tb_auth_engine: table-driven, scoreboard-checked bench for auth_engine.
// Adds PIN-change sequences when AUTH_PIN_CHANGE_EN is defined.
module tb_auth_engine;

   localparam int NUM_ACCOUNTS = 10;
   localparam int ACC_W        = 4;
   localparam int PIN_W        = 14;
   localparam int CNT_W        = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    req_valid_i = 1'b0;
   logic                    req_ready_o;
   logic [ACC_W-1:0]        req_acc_i = '0;
   logic [PIN_W-1:0]        req_pin_i = '0;
`ifdef AUTH_PIN_CHANGE_EN
   logic                    req_chg_i = 1'b0;
   logic [PIN_W-1:0]        req_new_pin_i = '0;
`endif
   logic                    resp_valid_o;
   logic                    resp_ready_i = 1'b0;
   logic [2:0]              resp_code_o;
   logic [CNT_W-1:0]        resp_tries_left_o;
   logic                    unlock_valid_i = 1'b0;
   logic [ACC_W-1:0]        unlock_acc_i = '0;
   logic [NUM_ACCOUNTS-1:0] locked_vec_o;

   typedef struct {
      logic [2:0]              code;
      logic [CNT_W-1:0]        tries;
      logic [NUM_ACCOUNTS-1:0] locked;
   } exp_t;

   typedef struct {
      logic                    unlockFirst;
      logic [ACC_W-1:0]        acc;
      logic [PIN_W-1:0]        pin;
      logic [2:0]              code;
      logic [CNT_W-1:0]        tries;
      logic [NUM_ACCOUNTS-1:0] locked;
   } vec_t;

   exp_t sbQ[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   auth_engine #(
      .NUM_ACCOUNTS(NUM_ACCOUNTS),
      .ACC_W(ACC_W),
      .PIN_W(PIN_W),
      .MAX_TRIES(3),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_acc_i(req_acc_i),
      .req_pin_i(req_pin_i),
`ifdef AUTH_PIN_CHANGE_EN
      .req_chg_i(req_chg_i),
      .req_new_pin_i(req_new_pin_i),
`endif
      .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i),
      .resp_code_o(resp_code_o),
      .resp_tries_left_o(resp_tries_left_o),
      .unlock_valid_i(unlock_valid_i),
      .unlock_acc_i(unlock_acc_i),
      .locked_vec_o(locked_vec_o)
   );

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mkExp(input logic [2:0] code, input logic [CNT_W-1:0] tries,
                                  input logic [NUM_ACCOUNTS-1:0] locked);
      exp_t e;
      e.code   = code;
      e.tries  = tries;
      e.locked = locked;
      return e;
   endfunction

   // Drives one request from a negedge and returns at the negedge after the accepting edge.
   task automatic applyStimulus(input logic [ACC_W-1:0] acc, input logic [PIN_W-1:0] pin,
                                input logic chg, input logic [PIN_W-1:0] newPin,
                                input bit push, input exp_t e);
      int budget = 0;
      while (!req_ready_o && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL req_ready_timeout actual=0 expected=1");
      end
      req_valid_i = 1'b1;
      req_acc_i   = acc;
      req_pin_i   = pin;
`ifdef AUTH_PIN_CHANGE_EN
      req_chg_i     = chg;
      req_new_pin_i = newPin;
`else
      if (chg || (newPin != '0)) begin
         $display("[TB] pin change request ignored in this build");
      end
`endif
      if (push) sbQ.push_back(e);
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      int budget = 0;
      while (!resp_valid_o && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (sbQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_scoreboard actual=empty expected=entry", tag);
         return;
      end
      e = sbQ.pop_front();
      if (!resp_valid_o) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_resp_timeout actual=0 expected=1", tag);
         return;
      end
      checkVal($sformatf("%s_code", tag), 32'(resp_code_o), 32'(e.code));
      checkVal($sformatf("%s_tries", tag), 32'(resp_tries_left_o), 32'(e.tries));
      checkVal($sformatf("%s_locked", tag), 32'(locked_vec_o), 32'(e.locked));
      resp_ready_i = 1'b1;
      @(negedge clk);
      resp_ready_i = 1'b0;
   endtask

   task automatic pulseUnlock(input logic [ACC_W-1:0] acc);
      unlock_valid_i = 1'b1;
      unlock_acc_i   = acc;
      @(negedge clk);
      unlock_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[13];
      vecs[0]  = '{1'b0, 4'd5,  14'd1111, 3'd1, 2'd2, 10'h000};
      vecs[1]  = '{1'b0, 4'd5,  14'd1111, 3'd1, 2'd1, 10'h000};
      vecs[2]  = '{1'b0, 4'd5,  14'd1111, 3'd2, 2'd0, 10'h020};
      vecs[3]  = '{1'b0, 4'd5,  14'd6789, 3'd2, 2'd0, 10'h020};
      vecs[4]  = '{1'b1, 4'd5,  14'd6789, 3'd0, 2'd3, 10'h000};
      vecs[5]  = '{1'b0, 4'd12, 14'd0,    3'd3, 2'd0, 10'h000};
      vecs[6]  = '{1'b0, 4'd9,  14'd1111, 3'd1, 2'd2, 10'h000};
      vecs[7]  = '{1'b0, 4'd9,  14'd1111, 3'd1, 2'd1, 10'h000};
      vecs[8]  = '{1'b0, 4'd9,  14'd7123, 3'd0, 2'd3, 10'h000};
      vecs[9]  = '{1'b0, 4'd9,  14'd1111, 3'd1, 2'd2, 10'h000};
      vecs[10] = '{1'b0, 4'd9,  14'd7123, 3'd0, 2'd3, 10'h000};
      vecs[11] = '{1'b0, 4'd15, 14'd1234, 3'd3, 2'd0, 10'h000};
      vecs[12] = '{1'b0, 4'd0,  14'd1234, 3'd0, 2'd3, 10'h000};

      repeat (3) @(negedge clk);
      checkVal("reset_req_ready", 32'(req_ready_o), 32'd1);
      checkVal("reset_resp_valid", 32'(resp_valid_o), 32'd0);
      checkVal("reset_resp_code", 32'(resp_code_o), 32'd0);
      checkVal("reset_tries", 32'(resp_tries_left_o), 32'd0);
      checkVal("reset_locked", 32'(locked_vec_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Accepting edge N: resp_valid low before edge N+1, high before edge N+2.
      applyStimulus(4'd2, 14'd3456, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkVal("lat_before_n1", 32'(resp_valid_o), 32'd0);
      @(negedge clk);
      checkVal("lat_at_n2", 32'(resp_valid_o), 32'd1);
      checkOutput("lat");

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].unlockFirst) pulseUnlock(vecs[i].acc);
         applyStimulus(vecs[i].acc, vecs[i].pin, 1'b0, '0, 1'b1,
                       mkExp(vecs[i].code, vecs[i].tries, vecs[i].locked));
         checkOutput($sformatf("vec%0d", i));
      end

      // Response held under backpressure while a competing request waits.
      applyStimulus(4'd1, 14'd2345, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      req_valid_i = 1'b1;
      req_acc_i   = 4'd3;
      req_pin_i   = 14'd1111;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         checkVal($sformatf("hold%0d_valid", k), 32'(resp_valid_o), 32'd1);
         checkVal($sformatf("hold%0d_code", k), 32'(resp_code_o), 32'd0);
         checkVal($sformatf("hold%0d_ready", k), 32'(req_ready_o), 32'd0);
         @(negedge clk);
      end
      req_valid_i = 1'b0;
      checkOutput("hold");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkVal($sformatf("no_accept%0d", k), 32'(resp_valid_o), 32'd0);
      end
      applyStimulus(4'd3, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd2, 10'h000));
      checkOutput("acc3_untouched");

      // Unlock landing on the CHECK edge: response sees the lock, stored state does not.
      applyStimulus(4'd7, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd2, 10'h000));
      checkOutput("lock7_a");
      applyStimulus(4'd7, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd1, 10'h000));
      checkOutput("lock7_b");
      applyStimulus(4'd7, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd2, 2'd0, 10'h080));
      checkOutput("lock7_c");
      applyStimulus(4'd7, 14'd8901, 1'b0, '0, 1'b1, mkExp(3'd2, 2'd0, 10'h000));
      pulseUnlock(4'd7);
      checkOutput("race7");
      applyStimulus(4'd7, 14'd8901, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("after_race7");

`ifdef AUTH_PIN_CHANGE_EN
      applyStimulus(4'd0, 14'd1234, 1'b1, 14'd4321, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("chg_ok");
      applyStimulus(4'd0, 14'd1234, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd2, 10'h000));
      checkOutput("chg_old_pin");
      applyStimulus(4'd0, 14'd4321, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("chg_new_pin");
      applyStimulus(4'd0, 14'd4321, 1'b1, 14'd12000, 1'b1, mkExp(3'd1, 2'd3, 10'h000));
      checkOutput("chg_bad_new");
      applyStimulus(4'd0, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd2, 10'h000));
      checkOutput("chg_cnt_kept");
      applyStimulus(4'd0, 14'd4321, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("chg_still_4321");
`endif

      // Reset in RESP abandons the response and restores locks and the PIN table.
      applyStimulus(4'd4, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd2, 10'h000));
      checkOutput("lock4_a");
      applyStimulus(4'd4, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd1, 2'd1, 10'h000));
      checkOutput("lock4_b");
      applyStimulus(4'd4, 14'd1111, 1'b0, '0, 1'b1, mkExp(3'd2, 2'd0, 10'h010));
      checkOutput("lock4_c");
      applyStimulus(4'd4, 14'd5678, 1'b0, '0, 1'b0, mkExp(3'd0, 2'd0, 10'h000));
      @(negedge clk);
      checkVal("rst_pre_valid", 32'(resp_valid_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkVal("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      checkVal("rst_req_ready", 32'(req_ready_o), 32'd1);
      checkVal("rst_locked", 32'(locked_vec_o), 32'd0);
      checkVal("rst_code", 32'(resp_code_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(4'd4, 14'd5678, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("post_rst4");
      applyStimulus(4'd0, 14'd1234, 1'b0, '0, 1'b1, mkExp(3'd0, 2'd3, 10'h000));
      checkOutput("post_rst0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
